// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the dmem port arbiter and its picker.
// Holds counter widths and the pointer-width helper.
package dmem_port_arbiter_pkg;

  localparam int MAX_REQ    = 8;
  localparam int PERF_CNT_W = 16;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_pick.sv
// Combinational round-robin one-hot picker.
// Searches upward from ptr with wrap-around.
module rr_pick
  import dmem_port_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int          sum;
  logic [PW-1:0] idx;
  logic        found;

  // Grant the first requester at or above ptr, wrapping past N-1.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = int'(ptr) + i;
      if (sum >= N) sum = sum - N;
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin share of one dmem port; 2-cycle fixed-latency responses.
// Optional perf counters under `DMEM_ARB_PERF_EN.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic [NUM_REQ-1:0]            i_REQ,
  input  logic [NUM_REQ-1:0]            i_WE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_WDATA,
  output logic [NUM_REQ-1:0]            o_GNT,
  output logic [NUM_REQ-1:0]            o_RVALID,
  output logic [DATA_WIDTH-1:0]         o_RDATA,
  output logic                          o_MEM_EN,
  output logic                          o_MEM_WE,
  output logic [ADDR_WIDTH-1:0]         o_MEM_ADDR,
  output logic [DATA_WIDTH-1:0]         o_MEM_WDATA,
  input  logic [DATA_WIDTH-1:0]         i_MEM_RDATA
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*PERF_CNT_W-1:0] o_PERF_GNT_CNT,
  output logic [PERF_CNT_W-1:0]         o_PERF_CONFLICT_CNT
`endif
);

  localparam int PW = ptr_w(NUM_REQ);

  logic [PW-1:0]         ptr_q, ptr_d, gidx;
  logic [NUM_REQ-1:0]    pick, gnt;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0]    tag1_q, tag1_d;
  logic [NUM_REQ-1:0]    tag2_q, tag2_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req (i_REQ),
    .ptr (ptr_q),
    .gnt (pick)
  );

  // Mux the granted access into the stage and advance the pointer.
  always_comb begin
    gnt         = i_RST ? '0 : pick;
    gidx        = '0;
    mem_en_d    = |gnt;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gidx        = PW'(i);
        mem_we_d    = i_WE[i];
        mem_addr_d  = i_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_d = i_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
    tag1_d  = gnt;
    tag2_d  = tag1_q;
    rdata_d = o_RDATA;
  end

  // Pointer, memory stage, owner tags and held read data.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      ptr_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      rdata_q     <= rdata_d;
    end
  end

  assign o_GNT       = gnt;
  assign o_RVALID    = tag2_q;
  assign o_RDATA     = (|tag2_q) ? i_MEM_RDATA : rdata_q;
  assign o_MEM_EN    = mem_en_q;
  assign o_MEM_WE    = mem_we_q;
  assign o_MEM_ADDR  = mem_addr_q;
  assign o_MEM_WDATA = mem_wdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [NUM_REQ*PERF_CNT_W-1:0] gcnt_q, gcnt_d;
  logic [PERF_CNT_W-1:0]         ccnt_q, ccnt_d;

  // Saturating per-requester grant and conflict counts.
  always_comb begin
    gcnt_d = gcnt_q;
    ccnt_d = ccnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] && gcnt_q[i*PERF_CNT_W +: PERF_CNT_W] != '1) begin
        gcnt_d[i*PERF_CNT_W +: PERF_CNT_W] =
          gcnt_q[i*PERF_CNT_W +: PERF_CNT_W] + 1'b1;
      end
    end
    if ($countones(i_REQ) > 1 && |(i_REQ & ~gnt)
        && ccnt_q != '1) begin
      ccnt_d = ccnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      gcnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      ccnt_q <= ccnt_d;
    end
  end

  assign o_PERF_GNT_CNT      = gcnt_q;
  assign o_PERF_CONFLICT_CNT = ccnt_q;
`endif

endmodule
